// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath/register-file geometry and the common word type.
package cpu_pkg;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned REG_NUM  = 2**ADDR_W;
   localparam int unsigned ZERO_REG = 0;

   typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID read-port bundle between the pipeline and the register file.
interface wb_regfile_if #(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
   parameter int unsigned CNT_W  = 32
);
   logic              RegWrite_i;
   logic              MemToReg_i;
   logic [ADDR_W-1:0] RDaddr_i;
   logic [DATA_W-1:0] RDData_i;
   logic [DATA_W-1:0] ALUResult_i;
   logic [ADDR_W-1:0] RSaddr_i;
   logic [ADDR_W-1:0] RTaddr_i;
   logic [DATA_W-1:0] RSdata_o;
   logic [DATA_W-1:0] RTdata_o;
   logic [DATA_W-1:0] WBdata_o;
   logic              WBvalid_o;
   logic [CNT_W-1:0]  WBcount_o;

   modport master (
      output RegWrite_i, MemToReg_i, RDaddr_i, RDData_i, ALUResult_i, RSaddr_i, RTaddr_i,
      input  RSdata_o, RTdata_o, WBdata_o, WBvalid_o, WBcount_o
   );

   modport slave (
      input  RegWrite_i, MemToReg_i, RDaddr_i, RDData_i, ALUResult_i, RSaddr_i, RTaddr_i,
      output RSdata_o, RTdata_o, WBdata_o, WBvalid_o, WBcount_o
   );
endinterface

// File: rtl/wb_select.sv
// Write-back value mux and commit decode; a write to the zero register never commits.
module wb_select
   import cpu_pkg::*;
#(
   parameter int unsigned DW = DATA_W,
   parameter int unsigned AW = ADDR_W
) (
   input  logic          reg_write,
   input  logic          mem_to_reg,
   input  logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   input  logic [DW-1:0] alu_result,
   output logic [DW-1:0] wb_data_c,
   output logic          wb_valid_c
);
   assign wb_data_c  = mem_to_reg ? rd_data : alu_result;
   assign wb_valid_c = reg_write && (rd_addr != AW'(ZERO_REG));
endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: commits the selected value to the register file, serves two bypassed
// read ports to ID and counts committed writes.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = cpu_pkg::DATA_W,
   parameter int unsigned ADDR_W = cpu_pkg::ADDR_W,
   parameter int unsigned CNT_W  = 32
) (
   input logic        clk_i,
   input logic        rst_n_i,
   wb_regfile_if.slave bus
);
   localparam int unsigned NUM_REGS = 2**ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] wb_data;
   logic              wb_valid;
   logic [CNT_W-1:0]  wb_cnt;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;

   wb_select #(
      .DW (DATA_W),
      .AW (ADDR_W)
   ) u_wb_select (
      .reg_write  (bus.RegWrite_i),
      .mem_to_reg (bus.MemToReg_i),
      .rd_addr    (bus.RDaddr_i),
      .rd_data    (bus.RDData_i),
      .alu_result (bus.ALUResult_i),
      .wb_data_c  (wb_data),
      .wb_valid_c (wb_valid)
   );

   // Array and counter only move on a committed write, so X data with RegWrite low is harmless.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
         wb_cnt <= '0;
      end else if (wb_valid) begin
         regs[bus.RDaddr_i] <= wb_data;
         wb_cnt             <= wb_cnt + CNT_W'(1);
      end
   end

   // Same-cycle write-through so ID sees the value being committed this cycle.
   always_comb begin
      rs_data = regs[bus.RSaddr_i];
      rt_data = regs[bus.RTaddr_i];
      if (bus.RSaddr_i == ADDR_W'(ZERO_REG)) begin
         rs_data = '0;
      end else if (wb_valid && (bus.RSaddr_i == bus.RDaddr_i)) begin
         rs_data = wb_data;
      end
      if (bus.RTaddr_i == ADDR_W'(ZERO_REG)) begin
         rt_data = '0;
      end else if (wb_valid && (bus.RTaddr_i == bus.RDaddr_i)) begin
         rt_data = wb_data;
      end
   end

   assign bus.RSdata_o  = rs_data;
   assign bus.RTdata_o  = rt_data;
   assign bus.WBdata_o  = wb_data;
   assign bus.WBvalid_o = wb_valid;
   assign bus.WBcount_o = wb_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a queue-scoreboarded random run.
module tb_wb_regfile;
   import cpu_pkg::*;

   logic clk_i;
   logic rst_n_i;

   wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
   wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus)
   );

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .bus     (bus4)
   );

   int    n_checks;
   int    n_fail;
   word_t sb_q [$];
   word_t model_regs [REG_NUM];
   int unsigned model_cnt;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic drive(input logic rw, input logic m2r, input logic [4:0] rd,
                        input word_t rdd, input word_t alu,
                        input logic [4:0] rs, input logic [4:0] rt);
      bus.RegWrite_i  = rw;
      bus.MemToReg_i  = m2r;
      bus.RDaddr_i    = rd;
      bus.RDData_i    = rdd;
      bus.ALUResult_i = alu;
      bus.RSaddr_i    = rs;
      bus.RTaddr_i    = rt;
   endtask

   task automatic test_reset();
      word_t exp;
      // Reset state right after power-on reset.
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd5, 5'd31);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rs got %h want %h", bus.RSdata_o, 32'h0); end
      n_checks++; if (bus.RTdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rt got %h want %h", bus.RTdata_o, 32'h0); end
      n_checks++; if (bus.WBcount_o !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.WBcount_o); end
      // Write reg[5] = 0x1234, then assert reset mid-cycle.
      drive(1'b1, 1'b0, 5'd5, 32'h0, 32'h1234, 5'd5, 5'd5);
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd5, 5'd5);
      exp = 32'h1234;
      #1;
      n_checks++; if (bus.RSdata_o !== exp) begin n_fail++; $display("FAIL reset_prewrite got %h want %h", bus.RSdata_o, exp); end
      n_checks++; if (bus.WBcount_o !== 32'd1) begin n_fail++; $display("FAIL reset_precnt got %0d want 1", bus.WBcount_o); end
      #1 rst_n_i = 1'b0;
      #1;
      n_checks++; if (bus.RSdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_async_rs got %h want %h", bus.RSdata_o, 32'h0); end
      n_checks++; if (bus.WBcount_o !== 32'h0) begin n_fail++; $display("FAIL reset_async_cnt got %0d want 0", bus.WBcount_o); end
      // A valid write presented during reset must not land.
      drive(1'b1, 1'b0, 5'd6, '0, 32'h55, 5'd6, 5'd6);
      @(posedge clk_i); #2;
      rst_n_i = 1'b1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd6, 5'd5);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_blocks_write got %h want %h", bus.RSdata_o, 32'h0); end
      n_checks++; if (bus.WBcount_o !== 32'h0) begin n_fail++; $display("FAIL reset_blocks_cnt got %0d want 0", bus.WBcount_o); end
   endtask

   task automatic test_alu_wb();
      @(posedge clk_i); #1;
      drive(1'b1, 1'b0, 5'd8, 32'h11111111, 32'hDEADBEEF, 5'd1, 5'd2);
      #1;
      n_checks++; if (bus.WBdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_wbdata got %h want %h", bus.WBdata_o, 32'hDEADBEEF); end
      n_checks++; if (bus.WBvalid_o !== 1'b1) begin n_fail++; $display("FAIL alu_wbvalid got %b want 1", bus.WBvalid_o); end
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd8, 5'd0);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_read got %h want %h", bus.RSdata_o, 32'hDEADBEEF); end
      n_checks++; if (bus.WBcount_o !== 32'd1) begin n_fail++; $display("FAIL alu_cnt got %0d want 1", bus.WBcount_o); end
   endtask

   task automatic test_mem_bypass();
      @(posedge clk_i); #1;
      drive(1'b1, 1'b1, 5'd3, 32'hCAFEF00D, 32'h22222222, 5'd3, 5'd3);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass_rs got %h want %h", bus.RSdata_o, 32'hCAFEF00D); end
      n_checks++; if (bus.RTdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass_rt got %h want %h", bus.RTdata_o, 32'hCAFEF00D); end
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd3, 5'd3);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mem_rs_after got %h want %h", bus.RSdata_o, 32'hCAFEF00D); end
      n_checks++; if (bus.RTdata_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mem_rt_after got %h want %h", bus.RTdata_o, 32'hCAFEF00D); end
      n_checks++; if (bus.WBcount_o !== 32'd2) begin n_fail++; $display("FAIL mem_cnt got %0d want 2", bus.WBcount_o); end
   endtask

   task automatic test_zero_reg();
      @(posedge clk_i); #1;
      drive(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'h0) begin n_fail++; $display("FAIL zero_rs got %h want %h", bus.RSdata_o, 32'h0); end
      n_checks++; if (bus.WBvalid_o !== 1'b0) begin n_fail++; $display("FAIL zero_wbvalid got %b want 0", bus.WBvalid_o); end
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
      #1;
      n_checks++; if (bus.RTdata_o !== 32'h0) begin n_fail++; $display("FAIL zero_after got %h want %h", bus.RTdata_o, 32'h0); end
      n_checks++; if (bus.WBcount_o !== 32'd2) begin n_fail++; $display("FAIL zero_cnt got %0d want 2", bus.WBcount_o); end
   endtask

   task automatic test_disabled();
      @(posedge clk_i); #1;
      drive(1'b1, 1'b0, 5'd9, '0, 32'h7, 5'd0, 5'd0);
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd9, 32'h0, 32'hAAAA5555, 5'd9, 5'd9);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'h7) begin n_fail++; $display("FAIL dis_nobypass got %h want %h", bus.RSdata_o, 32'h7); end
      n_checks++; if (bus.WBvalid_o !== 1'b0) begin n_fail++; $display("FAIL dis_wbvalid got %b want 0", bus.WBvalid_o); end
      n_checks++; if (bus.WBdata_o !== 32'hAAAA5555) begin n_fail++; $display("FAIL dis_wbdata got %h want %h", bus.WBdata_o, 32'hAAAA5555); end
      @(posedge clk_i); #1;
      // Unknown data with RegWrite low must leave the array intact.
      drive(1'b0, 1'bx, 5'd9, 'x, 'x, 5'd9, 5'd9);
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd9, 5'd8);
      #1;
      n_checks++; if (bus.RSdata_o !== 32'h7) begin n_fail++; $display("FAIL dis_after got %h want %h", bus.RSdata_o, 32'h7); end
      n_checks++; if (bus.RTdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dis_other got %h want %h", bus.RTdata_o, 32'hDEADBEEF); end
      n_checks++; if (bus.WBcount_o !== 32'd3) begin n_fail++; $display("FAIL dis_cnt got %0d want 3", bus.WBcount_o); end
   endtask

   task automatic test_back_to_back();
      logic        rw, m2r, commit;
      logic [4:0]  rd, rs, rt;
      word_t       rdd, alu, wbv, e;
      // Known model state from the directed tests.
      for (int i = 0; i < int'(REG_NUM); i++) model_regs[i] = '0;
      model_regs[8] = 32'hDEADBEEF;
      model_regs[3] = 32'hCAFEF00D;
      model_regs[9] = 32'h7;
      model_cnt     = 3;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk_i); #1;
         rw  = ($urandom_range(0, 3) != 0);
         m2r = 1'($urandom_range(0, 1));
         rd  = 5'($urandom_range(0, 31));
         rdd = $urandom;
         alu = $urandom;
         rs  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         rt  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         drive(rw, m2r, rd, rdd, alu, rs, rt);
         wbv    = m2r ? rdd : alu;
         commit = rw && (rd != 5'd0);
         sb_q.push_back((rs == 5'd0) ? 32'h0 : (commit && rs == rd) ? wbv : model_regs[rs]);
         sb_q.push_back((rt == 5'd0) ? 32'h0 : (commit && rt == rd) ? wbv : model_regs[rt]);
         sb_q.push_back(32'(model_cnt));
         #1;
         e = sb_q.pop_front();
         n_checks++; if (bus.RSdata_o !== e) begin n_fail++; $display("FAIL b2b_rs cyc %0d got %h want %h", c, bus.RSdata_o, e); end
         e = sb_q.pop_front();
         n_checks++; if (bus.RTdata_o !== e) begin n_fail++; $display("FAIL b2b_rt cyc %0d got %h want %h", c, bus.RTdata_o, e); end
         e = sb_q.pop_front();
         n_checks++; if (bus.WBcount_o !== e) begin n_fail++; $display("FAIL b2b_cnt cyc %0d got %0d want %0d", c, bus.WBcount_o, e); end
         if (commit) begin
            model_regs[rd] = wbv;
            model_cnt++;
         end
      end
      @(posedge clk_i); #1;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
   endtask

   task automatic test_counter_wrap();
      int unsigned cnt4;
      logic [3:0]  e;
      cnt4 = 0;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk_i); #1;
         bus4.RegWrite_i  = 1'b1;
         bus4.MemToReg_i  = 1'b0;
         bus4.RDaddr_i    = 5'(1 + (i % 31));
         bus4.ALUResult_i = 32'(i);
         bus4.RDData_i    = '0;
         cnt4 = (cnt4 + 1) % 16;
         sb_q.push_back(32'(cnt4));
         @(posedge clk_i); #1;
         bus4.RegWrite_i = 1'b0;
         if (i >= 14) begin
            e = 4'(sb_q.pop_front());
            n_checks++; if (bus4.WBcount_o !== e) begin n_fail++; $display("FAIL wrap_cnt write %0d got %0d want %0d", i + 1, bus4.WBcount_o, e); end
         end else begin
            void'(sb_q.pop_front());
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n_i  = 1'b0;
      drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
      bus4.RegWrite_i  = 1'b0;
      bus4.MemToReg_i  = 1'b0;
      bus4.RDaddr_i    = '0;
      bus4.RDData_i    = '0;
      bus4.ALUResult_i = '0;
      bus4.RSaddr_i    = '0;
      bus4.RTaddr_i    = '0;
      #12 rst_n_i = 1'b1;
      test_reset();
      test_alu_wb();
      test_mem_bypass();
      test_zero_reg();
      test_disabled();
      test_back_to_back();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
